tcdm_to_apb_bridge: RTL
=======================

TCDM_TO_APB_BRIDGE -- requirements
Module: tcdm_to_apb_bridge

Interface
REQ-001 SHALL have parameter NR_APB_SLAVES, default 2, number of APB slave ports (1..16).
REQ-002 SHALL have parameter NR_ADDR_RULES, default 2, number of address decode rules.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, TCDM/APB address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, data width (32 or 64).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 256, cycles allowed in ACCESS; 0 disables timeout.
REQ-006 SHALL have ports: clk_i  in  1  clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports: req_i in 1 request; gnt_o out 1 grant; add_i in ADDR_WIDTH address; wen_i in 1 (1=read, 0=write); wdata_i in DATA_WIDTH; be_i in DATA_WIDTH/8 byte enables.
REQ-008 SHALL have ports: r_valid_o out 1 response valid; r_rdata_o out DATA_WIDTH read data; r_opc_o out 1 error flag.
REQ-009 SHALL have port addr_map_i in NR_ADDR_RULES x addr_map_rule_t decode rules (idx, start_addr inclusive, end_addr exclusive).
REQ-010 SHALL have ports: paddr_o out ADDR_WIDTH; pwdata_o out DATA_WIDTH; pwrite_o out 1; pstrb_o out DATA_WIDTH/8; pprot_o out 3; penable_o out 1; psel_o out NR_APB_SLAVES one-hot.
REQ-011 SHALL have ports: pready_i in NR_APB_SLAVES; prdata_i in NR_APB_SLAVES x DATA_WIDTH; pslverr_i in NR_APB_SLAVES.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one transaction outstanding at a time.
REQ-013 SHALL assert gnt_o combinationally only in IDLE with req_i=1; gnt_o=0 in all other states.
REQ-014 SHALL register add_i, wen_i, wdata_i, be_i and decoded slave index on grant.
REQ-015 SHALL decode by lowest-numbered matching rule; rule idx >= NR_APB_SLAVES counts as no match.
REQ-016 On decode miss: IDLE -> RESP directly, no psel_o asserted, r_opc_o=1, r_rdata_o=0.
REQ-017 On decode hit: IDLE -> SETUP; SETUP drives psel_o[idx]=1, penable_o=0, one cycle, then -> ACCESS.
REQ-018 ACCESS SHALL drive psel_o[idx]=1, penable_o=1 until pready_i[idx]=1, then -> RESP, capturing prdata_i[idx] and pslverr_i[idx].
REQ-019 paddr_o, pwrite_o (=~wen), pwdata_o, pstrb_o SHALL be stable from SETUP through final ACCESS cycle; pstrb_o=be for writes, 0 for reads; pprot_o=3'b000.
REQ-020 pready_i/prdata_i/pslverr_i of non-selected slaves SHALL be ignored.
REQ-021 Timeout: counter counts ACCESS cycles; if TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES without pready, -> RESP with r_opc_o=1, r_rdata_o=0; psel_o/penable_o deasserted on exit.
REQ-022 pready_i in the same cycle the counter reaches limit SHALL win (normal completion).
REQ-023 RESP SHALL assert r_valid_o for exactly one cycle, for reads and writes; r_opc_o=captured pslverr; r_rdata_o=captured prdata for reads, 0 for writes; then -> IDLE.
REQ-024 Best-case latency: grant cycle N, r_valid_o at N+3 (hit, pready immediate); N+1 on decode miss.
REQ-025 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); no wrap-around, saturates at limit.
REQ-026 Outputs psel_o, penable_o, r_valid_o SHALL be 0 in IDLE.

Reset
REQ-027 rst_i=1 SHALL asynchronously force IDLE, counter=0, all outputs 0 (psel_o, penable_o, r_valid_o, r_opc_o, r_rdata_o, paddr_o, pwdata_o, pwrite_o, pstrb_o, gnt_o).
REQ-028 Reset mid-transaction SHALL abort it silently: no r_valid_o after reset release.

Structure
REQ-029 addr_map_rule_t SHALL come from pkg_soc_interconnect; FSM state enum local to the module.
REQ-030 Decode SHALL be a sub-module tcdm_apb_addr_decode (combinational, outputs idx and match).

Verification
REQ-031 Read hit: rule {idx 1, 0x1A10_0000..0x1A11_0000}, read 0x1A10_0004, slave1 pready in first ACCESS, prdata 0xCAFE_F00D -> psel_o=2'b10, r_valid_o at N+3, r_rdata_o=0xCAFE_F00D, r_opc_o=0.
REQ-032 Write with wait states: write 0x1A10_0008 data 0x1234_5678 be 4'b0011, pready after 4 ACCESS cycles -> pstrb_o=4'b0011 stable, r_valid_o at N+6, r_rdata_o=0.
REQ-033 Decode miss: read 0x0000_0000 -> no psel_o, r_valid_o at N+1, r_opc_o=1.
REQ-034 Timeout: TIMEOUT_CYCLES=8, pready held 0 -> r_valid_o at N+11 with r_opc_o=1, psel_o=0 afterwards; pready on 8th cycle -> normal response.
REQ-035 pslverr: slave returns pslverr=1 -> r_opc_o=1 with prdata forwarded; back-to-back req_i held high -> gnt_o only in IDLE, second grant at N+4.
REQ-036 Reset asserted in ACCESS -> all outputs 0 immediately, no r_valid_o after release, next request serviced normally.

Source files
------------

// File: rtl/tcdm_to_apb_bridge_pkg.sv
// Shared interconnect types: address decode rules used by the TCDM-to-APB bridge.
package pkg_soc_interconnect;

  localparam int unsigned RULE_FIELD_WIDTH = 32;

  typedef struct packed {
    logic [RULE_FIELD_WIDTH-1:0] idx;
    logic [RULE_FIELD_WIDTH-1:0] start_addr;
    logic [RULE_FIELD_WIDTH-1:0] end_addr;
  } addr_map_rule_t;

  // Address window is half-open: start inclusive, end exclusive.
  function automatic logic rule_hit(input addr_map_rule_t rule, input logic [63:0] addr);
    return (addr >= 64'(rule.start_addr)) && (addr < 64'(rule.end_addr));
  endfunction

endpackage

// File: rtl/tcdm_to_apb_bridge_addr_decode.sv
// Combinational address decoder: lowest-numbered matching rule with a valid slave index wins.
module tcdm_apb_addr_decode
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned NR_APB_SLAVES = 2,
  parameter int unsigned NR_ADDR_RULES = 2,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned IDX_WIDTH     = 1
) (
  input  logic [ADDR_WIDTH-1:0]                addr_i,
  input  addr_map_rule_t [NR_ADDR_RULES-1:0]   addr_map_i,
  output logic [IDX_WIDTH-1:0]                 idx_o,
  output logic                                 match_o
);

  always_comb begin
    idx_o   = '0;
    match_o = 1'b0;
    for (int i = 0; i < int'(NR_ADDR_RULES); i++) begin
      // Rules pointing past the last slave port are treated as if absent.
      if (!match_o && rule_hit(addr_map_i[i], 64'(addr_i)) &&
          (addr_map_i[i].idx < 32'(NR_APB_SLAVES))) begin
        match_o = 1'b1;
        idx_o   = addr_map_i[i].idx[IDX_WIDTH-1:0];
      end else begin
        match_o = match_o;
      end
    end
  end

endmodule

// File: rtl/tcdm_to_apb_bridge.sv
// TCDM slave to APB master bridge: one outstanding transfer, decoded to one of several APB slaves,
// with an optional ACCESS-phase timeout that returns an error response.
module tcdm_to_apb_bridge
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned NR_APB_SLAVES  = 2,
  parameter int unsigned NR_ADDR_RULES  = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_i,
  output logic                                   gnt_o,
  input  logic [ADDR_WIDTH-1:0]                  add_i,
  input  logic                                   wen_i,
  input  logic [DATA_WIDTH-1:0]                  wdata_i,
  input  logic [DATA_WIDTH/8-1:0]                be_i,
  output logic                                   r_valid_o,
  output logic [DATA_WIDTH-1:0]                  r_rdata_o,
  output logic                                   r_opc_o,
  input  addr_map_rule_t [NR_ADDR_RULES-1:0]     addr_map_i,
  output logic [ADDR_WIDTH-1:0]                  paddr_o,
  output logic [DATA_WIDTH-1:0]                  pwdata_o,
  output logic                                   pwrite_o,
  output logic [DATA_WIDTH/8-1:0]                pstrb_o,
  output logic [2:0]                             pprot_o,
  output logic                                   penable_o,
  output logic [NR_APB_SLAVES-1:0]               psel_o,
  input  logic [NR_APB_SLAVES-1:0]               pready_i,
  input  logic [NR_APB_SLAVES-1:0][DATA_WIDTH-1:0] prdata_i,
  input  logic [NR_APB_SLAVES-1:0]               pslverr_i
);

  localparam int unsigned IDX_WIDTH  = (NR_APB_SLAVES > 1) ? $clog2(NR_APB_SLAVES) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int unsigned CNT_WIDTH  = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic                  is_read;
  logic [IDX_WIDTH-1:0]  dec_idx;
  logic                  dec_match;
  logic                  take;
  logic                  timeout_hit;
  logic                  resp_opc;
  logic [DATA_WIDTH-1:0] resp_rdata;

  tcdm_apb_addr_decode #(
    .NR_APB_SLAVES (NR_APB_SLAVES),
    .NR_ADDR_RULES (NR_ADDR_RULES),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .IDX_WIDTH     (IDX_WIDTH)
  ) u_decode (
    .addr_i     (add_i),
    .addr_map_i (addr_map_i),
    .idx_o      (dec_idx),
    .match_o    (dec_match)
  );

  assign take        = (state == IDLE) && req_i;
  assign gnt_o       = take && !rst_i;
  assign pprot_o     = 3'b000;
  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LIMIT);

  always_comb begin
    next_state = state;
    cnt_next   = '0;
    resp_opc   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (dec_match) begin
            next_state = SETUP;
          end else begin
            next_state = RESP;
            resp_opc   = 1'b1;
          end
        end else begin
          next_state = IDLE;
        end
      end
      SETUP: next_state = ACCESS;
      ACCESS: begin
        // A ready arriving in the same cycle the limit is reached still completes normally.
        if (pready_i[sel_idx]) begin
          next_state = RESP;
          resp_opc   = pslverr_i[sel_idx];
          resp_rdata = is_read ? prdata_i[sel_idx] : '0;
        end else if (timeout_hit) begin
          next_state = RESP;
          resp_opc   = 1'b1;
        end else begin
          next_state = ACCESS;
          cnt_next   = TIMEOUT_EN ? (cnt + CNT_WIDTH'(1)) : cnt;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_idx   <= '0;
      is_read   <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pwrite_o  <= 1'b0;
      pstrb_o   <= '0;
      psel_o    <= '0;
      penable_o <= 1'b0;
      r_valid_o <= 1'b0;
      r_opc_o   <= 1'b0;
      r_rdata_o <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (take) begin
        sel_idx  <= dec_idx;
        is_read  <= wen_i;
        paddr_o  <= add_i;
        pwdata_o <= wdata_i;
        pwrite_o <= ~wen_i;
        pstrb_o  <= wen_i ? '0 : be_i;
      end
      // SETUP is only ever entered from IDLE, so the live decode result is the right select.
      if (next_state == SETUP) begin
        psel_o <= NR_APB_SLAVES'(1) << dec_idx;
      end else if (next_state == ACCESS) begin
        psel_o <= psel_o;
      end else begin
        psel_o <= '0;
      end
      penable_o <= (next_state == ACCESS);
      r_valid_o <= (next_state == RESP);
      r_opc_o   <= resp_opc;
      r_rdata_o <= resp_rdata;
    end
  end

endmodule
